// File: rtl/snn_link_pkg.sv
// snn_host_link shared types and constants.
// Frame geometry, FSM encoding and the digit-to-byte helper.
package snn_link_pkg;
  localparam int NUM_BYTES = 98;
  localparam int IMG_BITS  = 784;
  localparam int ADDR_W    = 10;
  localparam int BCNT_W    = ADDR_W - 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_TX,
    S_TX_WAIT
  } link_state_t;

  function automatic logic [7:0] digit_to_byte(input logic [3:0] digit);
    return {4'h0, digit};
  endfunction
endpackage

// File: rtl/snn_host_link_if.sv
// Bundle of uart, image RAM, core and board signals around snn_host_link.
// slave is the link controller side, master is its environment.
interface snn_host_link_if;
  import snn_link_pkg::*;

  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              core_start;
  logic              core_done;
  logic [3:0]        core_digit;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_rdy;
  logic [7:0]        led;
  logic              busy;
  logic              rx_drop;

  modport slave (
    input  rx_rdy, rx_data, core_done, core_digit, tx_rdy,
    output ram_we, ram_addr, ram_wdata, core_start,
    output tx_start, tx_data, led, busy, rx_drop
  );

  modport master (
    output rx_rdy, rx_data, core_done, core_digit, tx_rdy,
    input  ram_we, ram_addr, ram_wdata, core_start,
    input  tx_start, tx_data, led, busy, rx_drop
  );
endinterface

// File: rtl/byte_serializer.sv
// Byte to bit-stream unpacker, LSB first, with a one-byte skid buffer.
// Emits one bit per cycle while enabled and a byte_done on bit 7.
module byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       last_i,
  input  logic       rx_rdy_i,
  input  logic [7:0] rx_data_i,
  output logic       bit_vld_o,
  output logic       bit_o,
  output logic [2:0] bit_idx_o,
  output logic       byte_done_o,
  output logic       drop_o
);
  logic [7:0] hold_q, hold_d;
  logic [7:0] skid_q, skid_d;
  logic       hold_vld_q, hold_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       wr, done;

  assign wr          = en_i & hold_vld_q;
  assign done        = wr & (bit_cnt_q == 3'd7);
  assign bit_vld_o   = wr;
  assign bit_o       = hold_q[0];
  assign bit_idx_o   = bit_cnt_q;
  assign byte_done_o = done;

  always_comb begin
    hold_d     = hold_q;
    skid_d     = skid_q;
    hold_vld_d = hold_vld_q;
    skid_vld_d = skid_vld_q;
    bit_cnt_d  = bit_cnt_q;
    drop_o     = 1'b0;
    if (wr) begin
      hold_d    = hold_q >> 1;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (done) begin
      if (last_i) begin
        // frame complete: anything still queued belongs to no frame
        hold_vld_d = 1'b0;
        skid_vld_d = 1'b0;
        drop_o     = rx_rdy_i | skid_vld_q;
      end else if (skid_vld_q) begin
        hold_d     = skid_q;
        hold_vld_d = 1'b1;
        if (rx_rdy_i) skid_d = rx_data_i;
        else skid_vld_d = 1'b0;
      end else begin
        hold_d     = rx_data_i;
        hold_vld_d = rx_rdy_i;
      end
    end else if (en_i && rx_rdy_i) begin
      if (!hold_vld_q) begin
        hold_d     = rx_data_i;
        hold_vld_d = 1'b1;
      end else if (!skid_vld_q) begin
        skid_d     = rx_data_i;
        skid_vld_d = 1'b1;
      end else begin
        drop_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      skid_q     <= '0;
      hold_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      hold_q     <= hold_d;
      skid_q     <= skid_d;
      hold_vld_q <= hold_vld_d;
      skid_vld_q <= skid_vld_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/snn_host_link.sv
// Host link controller: loads a 784-bit image from uart bytes,
// runs the SNN core and returns the classified digit.
module snn_host_link
  import snn_link_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  snn_host_link_if.slave  bus
);
  link_state_t       state_q, state_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wdata_q, ram_wdata_d;
  logic              core_start_q, core_start_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        led_q, led_d;
  logic              busy_q, busy_d;
  logic              rx_drop_q, rx_drop_d;

  logic       ser_en, ser_last, ser_vld, ser_bit, ser_done, ser_drop;
  logic [2:0] ser_idx;

  assign ser_en   = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign ser_last = byte_cnt_q == BCNT_W'(NUM_BYTES - 1);

  byte_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .en_i        (ser_en),
    .last_i      (ser_last),
    .rx_rdy_i    (bus.rx_rdy),
    .rx_data_i   (bus.rx_data),
    .bit_vld_o   (ser_vld),
    .bit_o       (ser_bit),
    .bit_idx_o   (ser_idx),
    .byte_done_o (ser_done),
    .drop_o      (ser_drop)
  );

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    core_start_d = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    led_d        = led_q;
    ram_we_d     = ser_vld;
    ram_addr_d   = ser_vld ? {byte_cnt_q, ser_idx} : ram_addr_q;
    ram_wdata_d  = ser_vld ? ser_bit : ram_wdata_q;
    rx_drop_d    = rx_drop_q | ser_drop | (bus.rx_rdy & ~ser_en);
    unique case (state_q)
      S_IDLE: if (bus.rx_rdy) state_d = S_LOAD;
      S_LOAD: begin
        if (ser_done) begin
          if (ser_last) begin
            byte_cnt_d = '0;
            state_d    = S_START;
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end
      end
      S_START: begin
        core_start_d = 1'b1;
        state_d      = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.core_done) begin
          led_d     = digit_to_byte(bus.core_digit);
          tx_data_d = digit_to_byte(bus.core_digit);
          state_d   = S_TX;
        end
      end
      S_TX: begin
        if (bus.tx_rdy) begin
          tx_start_d = 1'b1;
          state_d    = S_TX_WAIT;
        end
      end
      // tx_rdy is stale while the uart is still seeing tx_start
      S_TX_WAIT: if (!tx_start_q && bus.tx_rdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 1'b0;
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      led_q        <= '0;
      busy_q       <= 1'b0;
      rx_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      core_start_q <= core_start_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      led_q        <= led_d;
      busy_q       <= busy_d;
      rx_drop_q    <= rx_drop_d;
    end
  end

  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.core_start = core_start_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.led        = led_q;
  assign bus.busy       = busy_q;
  assign bus.rx_drop    = rx_drop_q;
endmodule

// File: doc/snn_host_link.md
# snn_host_link

Host-side link controller for the SNN digit classifier. It is the responder to the PC-side initiator. It takes the 98 image bytes delivered by `uart_rx` and unpacks them, LSB first, into the 784×1-bit image RAM. It then starts the SNN core, and on completion returns the classified digit as one byte through `uart_tx` and latches it onto the board LEDs.

## Interface
- `NUM_BYTES`, 98, image bytes per frame
- `ADDR_W`, 10, image RAM address width (784 bits used)
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock; asynchronous, active-high
- `rx_rdy`  in  1  one-cycle pulse from `uart_rx`: `rx_data` valid
- `rx_data`  in  8  received byte
- `ram_we`  out  1  image RAM write enable
- `ram_addr`  out  ADDR_W  image RAM write address
- `ram_wdata`  out  1  image RAM write bit
- `core_start`  out  1  one-cycle pulse: image complete, begin inference
- `core_done`  in  1  one-cycle pulse from the core: `core_digit` valid
- `core_digit`  in  4  classified digit
- `tx_start`  out  1  one-cycle pulse to `uart_tx`
- `tx_data`  out  8  byte to transmit, `{4'h0, digit}`
- `tx_rdy`  in  1  `uart_tx` idle/ready level
- `led`  out  8  last result, `{4'h0, digit}`
- `busy`  out  1  high in every state except IDLE
- `rx_drop`  out  1  sticky: a received byte was discarded

## Operation
- FSM states: IDLE, LOAD, START, WAIT_DONE, TX, TX_WAIT.
- Counters:
  - `byte_cnt` runs 0..NUM_BYTES-1.
  - `bit_cnt` runs 0..7.
  - `hold` is an 8-bit shift register with a `hold_vld` flag.
  - `skid` is an 8-bit register with a `skid_vld` flag.
- IDLE:
  - `rx_rdy` loads `hold`, sets `hold_vld`, moves to LOAD.
- LOAD:
  - While `hold_vld` is set, each cycle writes one bit: `ram_we`=1, `ram_addr`=8·`byte_cnt`+`bit_cnt`, `ram_wdata`=`hold[0]`.
  - After each write, `hold` shifts right and `bit_cnt` increments.
  - Bit j of byte i lands at address 8i+j.
  - After bit 7: clear `bit_cnt`, increment `byte_cnt`.
  - If `skid_vld`, move `skid` into `hold` (next cycle writes that byte's bit 0); else clear `hold_vld`.
- `rx_rdy` in LOAD:
  - If `hold_vld`=0, or this cycle is the bit-7 write, the byte goes to `hold`.
  - Else, if the skid is empty, the byte goes to `skid`.
  - Else it is discarded and `rx_drop` sets.
- End of frame: when the bit-7 write of byte NUM_BYTES-1 completes, clear `byte_cnt` and go to START.
- START: `core_start`=1 for one cycle, then WAIT_DONE.
- WAIT_DONE:
  - On `core_done`: latch `digit` and update `led`, then go to TX.
- TX:
  - When `tx_rdy`=1, `tx_start`=1 for one cycle with `tx_data` stable, then go to TX_WAIT.
- TX_WAIT:
  - The cycle after `tx_start`, `tx_rdy` is ignored.
  - Thereafter `tx_rdy`=1 returns the FSM to IDLE.
- `rx_rdy` in START/WAIT_DONE/TX/TX_WAIT: byte discarded, `rx_drop` sets.
- `core_done` outside WAIT_DONE: ignored.
- `rx_drop` clears only on `rst`.
- Digit values above 9 pass through unmodified.

## Timing
- All outputs are registered.
- Reset values:
  - `ram_we`=0, `ram_addr`=0, `ram_wdata`=0
  - `core_start`=0, `tx_start`=0
  - `tx_data`=0, `led`=0
  - `busy`=0, `rx_drop`=0
  - state IDLE, all counters and valid flags 0.
- `rx_rdy` sampled at edge t produces a write of bit 0 at t+1 and bit 7 at t+8 (8 consecutive `ram_we` cycles).
- A back-to-back skid byte writes its bit 0 in the cycle after the previous byte's bit 7.
- The last write of byte 97 at cycle N gives `core_start` at N+1.
- `core_done` at t gives `led` and `tx_data` valid at t+1; `tx_start` comes no earlier than t+2.
- Asserting `rst` mid-frame aborts immediately: the partial image is abandoned (RAM contents untouched) and the next frame restarts at address 0.

## Structure
- `snn_link_pkg`:
  - FSM state enum `link_state_t`
  - `NUM_BYTES`=98, `IMG_BITS`=784, `ADDR_W`=10
  - function `digit_to_byte(digit)` returning `{4'h0, digit}`
- One sub-module, `byte_serializer`: `hold`/`skid` registers plus `bit_cnt`; emits a 1-bit stream and a `byte_done` pulse.
- The FSM and `byte_cnt` live in the top level.

## Test plan
- Frame of 98 bytes, byte i = i[7:0], spaced 1000 cycles → 784 writes, address 8i+j carries bit j of i; one `core_start`, 1 cycle after the final write.
- Two `rx_rdy` pulses 2 cycles apart (0xA5, 0x3C) → 16 contiguous writes, bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; `rx_drop`=0.
- Three `rx_rdy` pulses on consecutive cycles → first two bytes written, third discarded, `rx_drop`=1.
- `core_done` with `core_digit`=7, `tx_rdy`=0 for 50 cycles → `led`=0x07 the next cycle; `tx_start` is held off until `tx_rdy` rises, then one pulse with `tx_data`=0x07; returns to IDLE when `tx_rdy` returns high.
- `rx_rdy` during WAIT_DONE → no RAM write, `rx_drop`=1, state unchanged.
- `rst` after byte 40 of a frame → all outputs at reset values; a following full frame writes from address 0 and produces exactly one `core_start`.
